// File: rtl/rr_mux4.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux4
// Description : 4:1 round-robin packet mux; a granted channel holds the output
//               until its last beat, then priority rotates past it.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic [3:0]           in_valid,
    input  logic [3:0]           in_last,
    output logic [3:0]           in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_lock_ch;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;
    logic             r_out_last;
    logic             r_out_valid;

    logic             w_load_en;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic             w_any;
    logic [1:0]       w_grant_ch;
    logic             w_grant_vld;
    logic             w_xfer;
    logic             w_grant_last;
    logic [WIDTH-1:0] w_grant_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Rotate requests so the pointer channel sits at bit 0, then take the lowest.
    assign w_rot = 4'({in_valid, in_valid} >> r_ptr);

    always_comb begin
        w_off = 2'd0;
        w_any = 1'b1;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_any = 1'b0;
        endcase
    end

    always_comb begin
        w_grant_ch  = r_ptr + w_off;
        w_grant_vld = w_any;
        if (r_state == ST_LOCKED) begin
            w_grant_ch  = r_lock_ch;
            w_grant_vld = in_valid[r_lock_ch];
        end
    end

    assign in_ready     = (rst_n && w_load_en && w_grant_vld) ? (4'b0001 << w_grant_ch) : 4'b0000;
    assign w_xfer       = |in_ready;
    assign w_grant_last = in_last[w_grant_ch];
    assign w_grant_data = in_data[w_grant_ch*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_lock_ch   <= 2'd0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_out_data <= w_grant_data;
                r_out_sel  <= w_grant_ch;
                r_out_last <= w_grant_last;
                if (w_grant_last) begin
                    r_state <= ST_IDLE;
                    r_ptr   <= w_grant_ch + 2'd1;
                end else begin
                    r_state   <= ST_LOCKED;
                    r_lock_ch <= w_grant_ch;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux4
// Description : Directed bench for rr_mux4 with a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux4;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_valid;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux4 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: packet ownership and rotation tracked as plain integers.
    bit             m_init   = 1'b0;
    int             m_ptr    = 0;
    bit             m_locked = 1'b0;
    int             m_lock   = 0;
    bit             m_ov     = 1'b0;
    logic [WIDTH-1:0] m_od   = '0;
    int             m_os     = 0;
    bit             m_ol     = 1'b0;

    function automatic int pick();
        if (!rst_n || !(!m_ov || out_ready)) return -1;
        if (m_locked) return in_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < 4; k++)
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = pick();
        if (!rst_n) begin
            m_init = 1'b1; m_ptr = 0; m_locked = 1'b0; m_lock = 0;
            m_ov = 1'b0; m_od = '0; m_os = 0; m_ol = 1'b0;
        end else if (!m_ov || out_ready) begin
            if (g >= 0) begin
                m_ov = 1'b1;
                m_od = in_data[g*WIDTH +: WIDTH];
                m_os = g;
                m_ol = in_last[g];
                if (in_last[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % 4;
                end else begin
                    m_locked = 1'b1;
                    m_lock   = g;
                end
            end else begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            int g;
            g = pick();
            chk("cmp_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("cmp_valid", 32'(out_valid), 32'(m_ov));
            chk("cmp_data",  32'(out_data),  32'(m_od));
            chk("cmp_sel",   32'(out_sel),   32'(m_os));
            chk("cmp_last",  32'(out_last),  32'(m_ol));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 4'hF; in_last = 4'h0; in_data = '0; out_ready = 1'b1;

        // Reset with every channel requesting
        @(negedge clk); chk("rst_ready", 32'(in_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("rst_ready2", 32'(in_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        tick();

        // Round-robin over four single-beat channels
        rst_n = 1'b1; in_last = 4'hF;
        for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("rr_ready", 32'(in_ready), 32'd1 << (k % 4));
            tick();
            chk("rr_sel", 32'(out_sel), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'h0A0 + 32'(k % 4));
        end
        in_valid = 4'h0; tick();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Locked three-beat packet from ch2 with ptr=2
        in_valid = 4'b0010; tick();
        in_valid = 4'b0111;
        set_data(0, 8'h55); set_data(1, 8'h66);
        for (int b = 0; b < 3; b++) begin
            set_data(2, 8'h11 * 8'(b + 1));
            in_last = (b == 2) ? 4'b0111 : 4'b0011;
            @(negedge clk); chk("lock_ready", 32'(in_ready), 32'h4);
            tick();
            chk("lock_sel", 32'(out_sel), 32'h2);
            chk("lock_data", 32'(out_data), 32'h11 * 32'(b + 1));
        end
        @(negedge clk); chk("after_ready", 32'(in_ready), 32'h1);
        tick();
        chk("after_sel", 32'(out_sel), 32'h0);
        chk("after_data", 32'(out_data), 32'h55);
        in_valid = 4'h0; tick();

        // Backpressure holds the output and blocks all channels
        in_valid = 4'b0010; in_last = 4'hF; set_data(1, 8'h77); tick();
        chk("stall_pre_sel", 32'(out_sel), 32'h1);
        out_ready = 1'b0; in_valid = 4'hF; set_data(2, 8'h88);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("stall_ready", 32'(in_ready), 32'h0);
            tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'h77);
            chk("stall_sel", 32'(out_sel), 32'h1);
        end
        out_ready = 1'b1;
        @(negedge clk); chk("resume_ready", 32'(in_ready), 32'h4);
        tick();
        chk("resume_sel", 32'(out_sel), 32'h2);
        chk("resume_data", 32'(out_data), 32'h88);
        in_valid = 4'h0; tick();

        // Lock on ch1, valid drop keeps the lock, then reset discards it
        in_valid = 4'b0010; in_last = 4'h0; set_data(1, 8'h91);
        @(negedge clk); chk("lk1_ready", 32'(in_ready), 32'h2);
        tick();
        in_valid = 4'b0001; in_last = 4'b0001;
        @(negedge clk); chk("drop_ready", 32'(in_ready), 32'h0);
        tick();
        chk("drop_valid", 32'(out_valid), 32'h0);
        in_valid = 4'b0010; in_last = 4'h0; set_data(1, 8'h92);
        @(negedge clk); chk("relock_ready", 32'(in_ready), 32'h2);
        tick();
        chk("relock_data", 32'(out_data), 32'h92);
        rst_n = 1'b0;
        @(negedge clk); chk("rstmid_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rstmid_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1; in_valid = 4'b1000; in_last = 4'hF; set_data(3, 8'hC3);
        @(negedge clk); chk("post_ready", 32'(in_ready), 32'h8);
        tick();
        chk("post_valid", 32'(out_valid), 32'h1);
        chk("post_sel", 32'(out_sel), 32'h3);
        chk("post_data", 32'(out_data), 32'hC3);

        // Lone channel streams back-to-back single-beat packets
        in_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            set_data(1, 8'h10 + 8'(k));
            @(negedge clk); chk("stream_ready", 32'(in_ready), 32'h2);
            tick();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_sel", 32'(out_sel), 32'h1);
            chk("stream_data", 32'(out_data), 32'h10 + 32'(k));
        end
        in_valid = 4'h0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rr_mux4.md
RR_MUX4 -- requirements
Module: rr_mux4

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, data bits per channel.
REQ-002 The block SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port: in_data  input  4*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-005 The block SHALL have port: in_valid  input  4  per-channel beat valid.
REQ-006 The block SHALL have port: in_last  input  4  per-channel end-of-packet marker, qualified by in_valid.
REQ-007 The block SHALL have port: in_ready  output  4  per-channel accept, combinational.
REQ-008 The block SHALL have port: out_data  output  WIDTH  registered beat data.
REQ-009 The block SHALL have port: out_sel  output  2  registered source channel index, for a downstream 1:4 demux select.
REQ-010 The block SHALL have port: out_last  output  1  registered end-of-packet.
REQ-011 The block SHALL have port: out_valid  output  1  registered beat valid.
REQ-012 The block SHALL have port: out_ready  input  1  downstream accept.

Function
REQ-013 The block SHALL define load_en = !out_valid || out_ready; a channel SHALL transfer only in a cycle where in_valid[i] && in_ready[i].
REQ-014 The block SHALL assert at most one in_ready bit per cycle, and SHALL assert none when load_en=0.
REQ-015 In state IDLE with load_en=1, the block SHALL grant the first channel g with in_valid[g]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), and SHALL assert in_ready[g].
REQ-016 On a transfer from channel g, the block SHALL load out_data=in_data[g], out_sel=g, out_last=in_last[g], and out_valid=1 on the next edge, for a latency of 1 cycle.
REQ-017 On a transfer with in_last[g]=0 in IDLE, the block SHALL enter LOCKED with lock_ch=g and SHALL leave ptr unchanged.
REQ-018 On a transfer with in_last[g]=1 in IDLE, the block SHALL stay in IDLE and set ptr=(g+1) mod 4.
REQ-019 In LOCKED, the block SHALL set only in_ready[lock_ch] (=load_en && in_valid[lock_ch]), and SHALL hold all other in_ready bits at 0 regardless of their in_valid.
REQ-020 In LOCKED, on a transfer with in_last=1, the block SHALL return to IDLE and set ptr=(lock_ch+1) mod 4.
REQ-021 When load_en=1 and no transfer occurs, the block SHALL set out_valid=0 on the next edge; out_data, out_sel and out_last SHALL hold their values.
REQ-022 When out_valid=1 and out_ready=0, the block SHALL keep out_data, out_sel, out_last and out_valid stable.
REQ-023 With out_ready held at 1 and a grantable channel present every cycle, the block SHALL sustain one beat per cycle without bubbles.
REQ-024 The block SHALL wrap ptr from 3 to 0, and a lone valid channel SHALL be granted every eligible cycle.
REQ-025 A channel dropping in_valid mid-packet in LOCKED SHALL NOT release the lock.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL clear out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, and state=IDLE.
REQ-027 While rst_n=0, the block SHALL drive in_ready=4'b0000.
REQ-028 Reset asserted mid-packet SHALL discard the lock and any pending output beat; no partial beat SHALL appear after reset.

Verification
REQ-029 The bench SHALL cover: rst_n=0 for 2 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_sel=0, out_data=0.
REQ-030 The bench SHALL cover: all channels valid, in_last=1111, data ch i=8'hA0+i, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles with out_data A0,A1,A2,A3,A0.
REQ-031 The bench SHALL cover: ptr=2, ch2 sends 3 beats (11,22,33; last on 33) while ch0 and ch1 are valid and ch3 is idle -> out_sel 2,2,2, then 0; in_ready[0] and in_ready[1] stay 0 during the packet.
REQ-032 The bench SHALL cover: out_valid=1 with out_ready=0 for 3 cycles -> out_data and out_sel stable and in_ready=0000; after out_ready=1, the next beat appears 1 cycle later.
REQ-033 The bench SHALL cover: rst_n pulsed low during a locked ch1 packet, then only ch3 valid with last=1 -> ch3 is granted on the first cycle after reset, with out_sel=3.
REQ-034 The bench SHALL cover: only ch1 valid, streaming 6 single-beat packets with out_ready=1 -> 6 consecutive beats with out_sel=1 and no gaps.
